// File: rtl/bit_serial_word_driver_if.sv
// Word-side handshakes of the bit-serial add driver.
// Operand request channel plus result response channel.
interface bit_serial_word_driver_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_carry
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_carry
  );
endinterface

// File: rtl/bit_serial_word_driver.sv
// Host end of a bit-serial adder: shifts operands out LSB-first,
// gathers the serial sum and returns sum and carry as a word.
module bit_serial_word_driver #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  bit_serial_word_driver_if.slave bus,
  output logic ser_clr,
  output logic ser_a,
  output logic ser_b,
  input  logic ser_sum
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] s_sr;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             valid_q;

  logic             last;
  logic             cin_msb;
  logic             carry_nxt;
  logic [WIDTH-1:0] s_nxt;

  // Carry into the MSB is recovered from the MSB sum bit,
  // so the final carry needs no extra serial cycle.
  always_comb begin
    last      = (cnt == CW'(WIDTH - 1));
    cin_msb   = a_sr[0] ^ b_sr[0] ^ ser_sum;
    carry_nxt = (a_sr[0] & b_sr[0])
              | (a_sr[0] & cin_msb)
              | (b_sr[0] & cin_msb);
    s_nxt     = {ser_sum, s_sr[WIDTH-1:1]};
  end

  // Outputs decoded from state; carry clear held outside SHIFT.
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = valid_q;
    bus.out_sum   = sum_q;
    bus.out_carry = carry_q;
    ser_clr       = (state != SHIFT);
    ser_a         = (state == SHIFT) ? a_sr[0] : 1'b0;
    ser_b         = (state == SHIFT) ? b_sr[0] : 1'b0;
  end

  // Sequencer: load, WIDTH shift cycles, hold result until taken.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      a_sr    <= '0;
      b_sr    <= '0;
      s_sr    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sr  <= bus.in_a;
            b_sr  <= bus.in_b;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          s_sr <= s_nxt;
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          cnt  <= cnt + 1'b1;
          if (last) begin
            sum_q   <= s_nxt;
            carry_q <= carry_nxt;
            valid_q <= 1'b1;
            cnt     <= '0;
            state   <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bit_serial_word_driver.sv
// Bench for bit_serial_word_driver with a behavioural serial adder
// and a word-level a+b reference model.
module tb_bit_serial_word_driver;
  localparam int W = 8;
  localparam int N = 1000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ser_clr, ser_a, ser_b, ser_sum;
  logic add_c = 1'b0;

  int tests = 0;
  int errs  = 0;

  bit_serial_word_driver_if #(.WIDTH(W)) bus ();

  bit_serial_word_driver #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .ser_clr (ser_clr),
    .ser_a   (ser_a),
    .ser_b   (ser_b),
    .ser_sum (ser_sum)
  );

  always #5 clk = ~clk;

  // External serial adder: one carry flop, cleared by ser_clr.
  assign ser_sum = ser_a ^ ser_b ^ add_c;
  always @(posedge clk) begin
    if (ser_clr) add_c <= 1'b0;
    else add_c <= (ser_a & ser_b) | (ser_a & add_c) | (ser_b & add_c);
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(logic [W-1:0] a, logic [W-1:0] b, int hold);
    logic [W:0] e;
    e = {1'b0, a} + {1'b0, b};
    bus.in_a = a;
    bus.in_b = b;
    bus.in_valid = 1'b1;
    chk("acc_rdy", 32'(bus.in_ready), 1);
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      chk("ser_a", 32'(ser_a), 32'(a[i]));
      chk("ser_b", 32'(ser_b), 32'(b[i]));
      chk("ser_clr", 32'(ser_clr), 0);
      chk("busy_ov", 32'(bus.out_valid), 0);
      step();
    end
    chk("ov", 32'(bus.out_valid), 1);
    chk("sum", 32'(bus.out_sum), 32'(e[W-1:0]));
    chk("carry", 32'(bus.out_carry), 32'(e[W]));
    chk("done_clr", 32'(ser_clr), 1);
    chk("done_rdy", 32'(bus.in_ready), 0);
    bus.out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = (h == 1);
      bus.in_a = ~a;
      step();
      chk("hold_ov", 32'(bus.out_valid), 1);
      chk("hold_sum", 32'(bus.out_sum), 32'(e[W-1:0]));
      chk("hold_rdy", 32'(bus.in_ready), 0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("ack_ov", 32'(bus.out_valid), 0);
    chk("ack_rdy", 32'(bus.in_ready), 1);
    chk("ack_sum", 32'(bus.out_sum), 32'(e[W-1:0]));
  endtask

  initial begin
    logic [W:0] q[$];
    int acc, got, cyc;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    repeat (3) step();
    chk("rst_ov", 32'(bus.out_valid), 0);
    chk("rst_sum", 32'(bus.out_sum), 0);
    chk("rst_carry", 32'(bus.out_carry), 0);
    chk("rst_rdy", 32'(bus.in_ready), 1);
    chk("rst_clr", 32'(ser_clr), 1);
    reset = 1'b1;
    step();

    run_txn(8'h5A, 8'h33, 0);
    run_txn(8'hFF, 8'h01, 0);
    run_txn(8'h12, 8'h34, 5);

    bus.in_a = 8'hF0;
    bus.in_b = 8'h0F;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (3) step();
    chk("mid_ser_a", 32'(ser_a), 0);
    chk("mid_ser_b", 32'(ser_b), 1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("mrst_ov", 32'(bus.out_valid), 0);
    chk("mrst_clr", 32'(ser_clr), 1);
    chk("mrst_sum", 32'(bus.out_sum), 0);
    chk("mrst_rdy", 32'(bus.in_ready), 1);
    run_txn(8'h80, 8'h80, 0);

    run_txn(8'hFF, 8'hFF, 0);
    run_txn(8'h00, 8'h00, 0);

    acc = 0;
    got = 0;
    cyc = 0;
    while (got < N && cyc < 60000) begin
      bus.in_valid  = (acc < N) && ($urandom_range(0, 3) != 0);
      bus.in_a      = W'($urandom);
      bus.in_b      = W'($urandom);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      #3;
      if (bus.in_valid && bus.in_ready) begin
        q.push_back({1'b0, bus.in_a} + {1'b0, bus.in_b});
        acc++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) chk("rnd_extra", 1, 0);
        else chk("rnd", 32'({bus.out_carry, bus.out_sum}), 32'(q.pop_front()));
        got++;
      end
      step();
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    chk("rnd_count", got, N);
    chk("rnd_left", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule

// File: doc/bit_serial_word_driver.md
Name: bit_serial_word_driver

Overview:
Word-level host end of the bit-serial add interface. Accepts a pair of WIDTH-bit operands over a valid/ready handshake. Drives them LSB-first to an external bit-serial adder along with that adder's active-high carry clear, collects the serial sum bits, and returns the parallel sum and final carry over a second valid/ready handshake. Sits between word-oriented datapath logic and the serial adder.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range WIDTH >= 2

Ports:
clk  input  1  rising-edge clock, shared with the serial adder
reset  input  1  synchronous, active-low reset (0 = reset)
in_valid  input  1  operand pair valid
in_ready  output  1  driver can accept operands
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
ser_clr  output  1  active-high carry clear to the serial adder's reset input
ser_a  output  1  serial operand A bit, LSB-first
ser_b  output  1  serial operand B bit, LSB-first
ser_sum  input  1  serial sum bit from the adder; combinational in ser_a/ser_b for the current cycle
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_sum  output  WIDTH  (in_a + in_b) mod 2^WIDTH
out_carry  output  1  carry out of bit WIDTH-1

Behaviour:
- Reset is sampled on the clk edge; reset==0 forces state IDLE.
  - out_valid=0, out_sum=0, out_carry=0, bit counter=0, operand shift registers=0.
  - Applies from any state, including mid-SHIFT and DONE; any partial result is discarded without a handshake.
- Decoded outputs:
  - in_ready = (state==IDLE).
  - ser_clr = 1 in IDLE and DONE, 0 in SHIFT.
  - ser_a/ser_b = LSB of the operand shift registers in SHIFT, else 0.
- IDLE:
  - ser_clr=1 guarantees the adder's carry register is 0 on the edge that leaves IDLE.
  - On in_valid && in_ready: load in_a/in_b into the shift registers, counter=0, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT (exactly WIDTH cycles):
  - Each cycle, sample ser_sum into the sum shift register, entering at the MSB and shifting right.
  - Shift both operand registers right; counter increments.
  - At counter==WIDTH-1, latch the MSB operand bits needed for carry, then go to DONE and set out_valid=1 on that same edge.
- Carry computation:
  - cin_msb = a_msb ^ b_msb ^ sum_msb.
  - out_carry = majority(a_msb, b_msb, cin_msb).
  - No extra serial cycle is used.
- DONE:
  - out_valid=1; out_sum/out_carry held stable.
  - On out_ready: out_valid=0 at the edge, go to IDLE.
  - out_ready low holds all outputs indefinitely.
- Latency and throughput:
  - Accept edge at cycle 0; ser bits for bit i are presented in cycle i+1; out_valid is high from cycle WIDTH+1.
  - Minimum interval between accepts is WIDTH+2 cycles; no overlap.
- Ignored inputs:
  - in_valid outside IDLE is ignored and operands are not sampled.
  - out_ready outside DONE is ignored.
- out_sum and out_carry keep their last result after the DONE→IDLE handoff until overwritten by the next DONE or cleared by reset.

Test Plan:
1. WIDTH=8, in_a=0x5A, in_b=0x33 accepted at cycle 0.
   - ser_a in cycles 1..8 = 0,1,0,1,1,0,1,0; ser_b = 1,1,0,0,1,1,0,0.
   - out_valid rises at cycle 9 with out_sum=0x8D, out_carry=0.
2. 0xFF+0x01 -> out_sum=0x00, out_carry=1; ser_clr=0 only in cycles 1..8.
3. Result 0x12+0x34: hold out_ready=0 for 5 cycles after out_valid.
   - out_sum=0x46 stays stable; in_ready=0; an in_valid pulse in this window is not accepted.
   - out_ready=1 -> out_valid=0 and in_ready=1 next cycle.
4. Drop reset to 0 during bit 3 of 0xF0+0x0F.
   - Next cycle: IDLE, out_valid=0, ser_clr=1, out_sum=0.
   - Then 0x80+0x80 -> out_sum=0x00, out_carry=1, showing no stale carry.
5. Back-to-back: 0xFF+0xFF -> 0xFE with carry 1, then immediately 0x00+0x00 -> 0x00 with carry 0.
   - Second transaction accepted exactly 1 cycle after the first out handshake.
6. Randomised operands plus randomised in_valid/out_ready stalls, 1000 transactions.
   - Every result equals {carry,sum} = in_a+in_b; no transaction dropped or duplicated.
